// File: rtl/gray_cnt_sync_if.sv
// Counter bus for gray_cnt_sync.
//   inc      : increment request, sampled every rising edge (level, one count per cycle)
//   cnt_a    : binary source counter
//   cnt_gray : registered Gray code of cnt_a (the only signal feeding the synchroniser)
//   cnt_b    : binary decode of the last synchroniser stage
// The master modport is the side that drives inc and reads the counts.
// The slave modport is the counter core.
interface gray_cnt_sync_if #(
    parameter int WIDTH = 8
);
    logic             inc;
    logic [WIDTH-1:0] cnt_a;
    logic [WIDTH-1:0] cnt_gray;
    logic [WIDTH-1:0] cnt_b;

    modport master (
        output inc,
        input  cnt_a,
        input  cnt_gray,
        input  cnt_b
    );

    modport slave (
        input  inc,
        output cnt_a,
        output cnt_gray,
        output cnt_b
    );
endinterface

// File: rtl/gray_cnt_sync.sv
// Event counter with a Gray-coded, multi-stage synchronised copy of its value.
// This is the single-clock core of the clock-crossing counter path.
//   clk          : single clock, rising edge
//   rst          : asynchronous active-high reset, clears all state
//   bus.inc      : increment request, one count per cycle while high
//   bus.cnt_a    : binary source counter (wraps silently)
//   bus.cnt_gray : Gray code of cnt_a, registered alongside it (no extra latency)
//   bus.cnt_b    : binary decode of the last sync stage, lags cnt_a by SYNC_STAGES cycles
module gray_cnt_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    gray_cnt_sync_if.slave bus
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
        $error("gray_cnt_sync: SYNC_STAGES must be in 2..4");
    end

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] cnt_a_p0;
    logic [WIDTH-1:0] gray_p0;
    logic [WIDTH-1:0] sync_p [SYNC_STAGES];
    logic [WIDTH-1:0] next_bin;

    // Source counter stage: Gray is computed from the value cnt_a is about to
    // take, so both registers update together and cnt_gray == gray(cnt_a).
    always_comb begin
        next_bin = cnt_a_p0;
        if (bus.inc) begin
            next_bin = cnt_a_p0 + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_a_p0 <= '0;
            gray_p0  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_p[i] <= '0;
            end
        end else begin
            cnt_a_p0 <= next_bin;
            gray_p0  <= bin2gray(next_bin);
            // Synchroniser stages: pure flop-to-flop Gray transport, nothing in between.
            sync_p[0] <= gray_p0;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_p[i] <= sync_p[i-1];
            end
        end
    end

    // Decode stage: combinational from the last synchroniser flop.
    assign bus.cnt_a    = cnt_a_p0;
    assign bus.cnt_gray = gray_p0;
    assign bus.cnt_b    = gray2bin(sync_p[SYNC_STAGES-1]);

endmodule

// File: tb/tb_gray_cnt_sync.sv
module tb_gray_cnt_sync;
    logic clk;
    logic rst;
    logic inc;

    int checks;
    int errors;

    // Reference: ma is the expected cnt_a; hist[k] is the expected cnt_a k edges ago.
    logic [7:0] ma;
    logic [7:0] hist [0:3];

    gray_cnt_sync_if #(.WIDTH(8)) bus2 ();
    gray_cnt_sync_if #(.WIDTH(8)) bus3 ();

    assign bus2.inc = inc;
    assign bus3.inc = inc;

    gray_cnt_sync #(.WIDTH(8), .SYNC_STAGES(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    gray_cnt_sync #(.WIDTH(8), .SYNC_STAGES(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Apply inc for one edge, then advance the reference model; returns #1 after the edge.
    task automatic tick(input logic i);
        inc = i;
        @(posedge clk);
        #1;
        if (rst) begin
            ma = 8'h00;
            for (int k = 0; k < 4; k++) hist[k] = 8'h00;
        end else begin
            if (i) ma = ma + 8'h01;
            for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = ma;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ma  = 8'h00;
        for (int k = 0; k < 4; k++) hist[k] = 8'h00;
        tick(1'b0);
        tick(1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] exp_a [5];
        logic [7:0] exp_b [5];
        exp_a = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        exp_b = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd3};
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick(1'b1);
            checks++;
            if (bus2.cnt_a !== 8'h00 || bus2.cnt_gray !== 8'h00 || bus2.cnt_b !== 8'h00 || bus3.cnt_b !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d a=%h gray=%h b=%h b3=%h required all 00",
                         c, bus2.cnt_a, bus2.cnt_gray, bus2.cnt_b, bus3.cnt_b);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick(1'b1);
            checks++;
            if (bus2.cnt_a !== exp_a[c] || bus2.cnt_b !== exp_b[c]) begin
                errors++;
                $display("FAIL reset_release cyc=%0d a=%h b=%h required a=%h b=%h",
                         c, bus2.cnt_a, bus2.cnt_b, exp_a[c], exp_b[c]);
            end
        end
    endtask

    task automatic test_gated();
        logic       pat   [5];
        logic [7:0] exp_a [5];
        logic [7:0] exp_g [5];
        pat   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_a = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd3};
        exp_g = '{8'h01, 8'h01, 8'h03, 8'h02, 8'h02};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            tick(c < 5 ? pat[c] : 1'b0);
            if (c < 5) begin
                checks++;
                if (bus2.cnt_a !== exp_a[c] || bus2.cnt_gray !== exp_g[c]) begin
                    errors++;
                    $display("FAIL gated cyc=%0d a=%h gray=%h required a=%h gray=%h",
                             c, bus2.cnt_a, bus2.cnt_gray, exp_a[c], exp_g[c]);
                end
            end
            checks++;
            if (bus2.cnt_b !== (c >= 2 ? exp_a[c-2] : 8'h00)) begin
                errors++;
                $display("FAIL gated_b cyc=%0d b=%h required %h",
                         c, bus2.cnt_b, (c >= 2 ? exp_a[c-2] : 8'h00));
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_a [3];
        logic [7:0] exp_g [3];
        exp_a = '{8'hFF, 8'h00, 8'h01};
        exp_g = '{8'h80, 8'h00, 8'h01};
        do_reset();
        repeat (254) tick(1'b1);
        checks++;
        if (bus2.cnt_a !== 8'd254) begin
            errors++;
            $display("FAIL wrap_preload a=%h required fe", bus2.cnt_a);
        end
        for (int c = 0; c < 3; c++) begin
            tick(1'b1);
            checks++;
            if (bus2.cnt_a !== exp_a[c] || bus2.cnt_gray !== exp_g[c]) begin
                errors++;
                $display("FAIL wrap cyc=%0d a=%h gray=%h required a=%h gray=%h",
                         c, bus2.cnt_a, bus2.cnt_gray, exp_a[c], exp_g[c]);
            end
        end
        // cnt_a hit 0 on the second wrap edge; cnt_b must show 0 two edges later.
        tick(1'b0);
        checks++;
        if (bus2.cnt_b !== 8'h00) begin
            errors++;
            $display("FAIL wrap_b b=%h required 00", bus2.cnt_b);
        end
    endtask

    task automatic test_random();
        logic [7:0] prev_g;
        logic [7:0] prev_b;
        do_reset();
        prev_g = bus2.cnt_gray;
        prev_b = bus2.cnt_b;
        for (int c = 0; c < 2000; c++) begin
            tick(1'($urandom_range(0, 1)));
            checks++;
            if (bus2.cnt_a !== ma || bus2.cnt_b !== hist[2] || bus3.cnt_b !== hist[3]) begin
                errors++;
                $display("FAIL random_lat cyc=%0d a=%h b=%h b3=%h required a=%h b=%h b3=%h",
                         c, bus2.cnt_a, bus2.cnt_b, bus3.cnt_b, ma, hist[2], hist[3]);
            end
            checks++;
            if ($countones(bus2.cnt_gray ^ prev_g) > 1 ||
                (bus2.cnt_gray !== (ma ^ (ma >> 1)))) begin
                errors++;
                $display("FAIL random_gray cyc=%0d gray=%h prev=%h required %h",
                         c, bus2.cnt_gray, prev_g, ma ^ (ma >> 1));
            end
            checks++;
            if (bus2.cnt_b !== prev_b && bus2.cnt_b !== prev_b + 8'h01) begin
                errors++;
                $display("FAIL random_mono cyc=%0d b=%h prev=%h required step 0 or +1",
                         c, bus2.cnt_b, prev_b);
            end
            prev_g = bus2.cnt_gray;
            prev_b = bus2.cnt_b;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (8'h37) tick(1'b1);
        checks++;
        if (bus2.cnt_a !== 8'h37) begin
            errors++;
            $display("FAIL async_pre a=%h required 37", bus2.cnt_a);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus2.cnt_a !== 8'h00 || bus2.cnt_gray !== 8'h00 || bus2.cnt_b !== 8'h00 ||
            bus3.cnt_a !== 8'h00 || bus3.cnt_b !== 8'h00) begin
            errors++;
            $display("FAIL async_clear a=%h gray=%h b=%h a3=%h b3=%h required all 00",
                     bus2.cnt_a, bus2.cnt_gray, bus2.cnt_b, bus3.cnt_a, bus3.cnt_b);
        end
        ma = 8'h00;
        for (int k = 0; k < 4; k++) hist[k] = 8'h00;
        tick(1'b1);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick(1'b1);
            checks++;
            if (bus2.cnt_b === 8'h37 || bus2.cnt_b === 8'h36 || bus2.cnt_b !== hist[2] ||
                bus3.cnt_b === 8'h37 || bus3.cnt_b === 8'h36) begin
                errors++;
                $display("FAIL async_stale cyc=%0d b=%h b3=%h required b=%h",
                         c, bus2.cnt_b, bus3.cnt_b, hist[2]);
            end
        end
    endtask

    task automatic test_stages3();
        logic [7:0] exp_b3;
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            tick(1'b1);
            exp_b3 = (k >= 3) ? 8'(k - 3) : 8'h00;
            checks++;
            if (bus3.cnt_a !== 8'(k) || bus3.cnt_b !== exp_b3) begin
                errors++;
                $display("FAIL stages3 k=%0d a3=%h b3=%h required a3=%h b3=%h",
                         k, bus3.cnt_a, bus3.cnt_b, 8'(k), exp_b3);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        inc    = 1'b0;
        ma     = 8'h00;
        for (int k = 0; k < 4; k++) hist[k] = 8'h00;
        test_reset();
        test_gated();
        test_wrap();
        test_random();
        test_async_reset();
        test_stages3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
